// File: rtl/uart_rx_ctrl_if.sv
// Bundles the receiver-side and CPU-side signals of the UART receive controller.
// The controller attaches through the slave modport. The environment, either a
// CPU model or a testbench, attaches through the master modport.
interface uart_rx_ctrl_if #(
    parameter int AW = 3
);
    logic [3:0]  cnt16x;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_parity_error;
    logic        rx_frame_error;
    logic        rx_rdn;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic        rd_ferr;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overrun;
    logic        clr_ovr;
    logic [7:0]  perr_cnt;
    logic [7:0]  ferr_cnt;
    logic        clr_cnt;
    logic        irq_en;
    logic        irq;

    modport slave (
        input  rx_ready, rx_data, rx_parity_error, rx_frame_error,
        input  rd_en, clr_ovr, clr_cnt, irq_en,
        output cnt16x, rx_rdn, rd_data, rd_perr, rd_ferr,
        output empty, full, count, overrun, perr_cnt, ferr_cnt, irq
    );

    modport master (
        output rx_ready, rx_data, rx_parity_error, rx_frame_error,
        output rd_en, clr_ovr, clr_cnt, irq_en,
        input  cnt16x, rx_rdn, rd_data, rd_perr, rd_ferr,
        input  empty, full, count, overrun, perr_cnt, ferr_cnt, irq
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the UART receiver, clocked by the x16 baud clock.
// It drives the free-running cnt16x count and pulls bytes out of the receiver
// with a held active-low read strobe. Each byte and its error flags go into a
// first-word-fall-through FIFO that the CPU drains. The block also tracks
// overrun, keeps saturating error counts and raises an interrupt.
module uart_rx_ctrl #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int RDN_CYCLES = 16
) (
    input  logic           clk16x,
    input  logic           clr,
    uart_rx_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [4:0]  RDN_LAST   = 5'(RDN_CYCLES - 1);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    state_t         r_state;
    state_t         w_stateNext;
    logic           r_rdn;
    logic           w_rdnNext;
    logic [4:0]     r_rdnCnt;
    logic [4:0]     w_rdnCntNext;
    logic           w_push;

    logic [3:0]     r_cnt16;

    logic [9:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [AW:0]    r_count;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_pushAccept;
    logic           w_drop;
    logic [9:0]     w_entry;
    logic [9:0]     w_head;

    logic           r_overrun;
    logic [7:0]     r_perrCnt;
    logic [7:0]     r_ferrCnt;
    logic [7:0]     w_perrNext;
    logic [7:0]     w_ferrNext;
    logic           r_irq;

    // Free-running x16 phase counter that the receiver uses for bit sampling.
    always_ff @(posedge clk16x) begin
        if (clr) begin
            r_cnt16 <= 4'd0;
        end else begin
            r_cnt16 <= r_cnt16 + 4'd1;
        end
    end

    // Registers the strobe FSM state, the strobe itself and the hold counter.
    always_ff @(posedge clk16x) begin
        if (clr) begin
            r_state  <= IDLE;
            r_rdn    <= 1'b1;
            r_rdnCnt <= 5'd0;
        end else begin
            r_state  <= w_stateNext;
            r_rdn    <= w_rdnNext;
            r_rdnCnt <= w_rdnCntNext;
        end
    end

    // Next-state logic: the strobe drops as soon as the receiver is ready. The
    // FIFO push happens on the first READ cycle, and the strobe stays held long
    // enough that the receiver cannot re-flag the same frame.
    always_comb begin
        w_stateNext  = r_state;
        w_rdnNext    = r_rdn;
        w_rdnCntNext = r_rdnCnt;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                w_rdnNext = 1'b1;
                if (bus.rx_ready) begin
                    w_stateNext  = READ;
                    w_rdnNext    = 1'b0;
                    w_rdnCntNext = 5'd0;
                end
            end
            READ: begin
                w_push = (r_rdnCnt == 5'd0);
                if (r_rdnCnt == RDN_LAST) begin
                    w_stateNext = IDLE;
                    w_rdnNext   = 1'b1;
                end else begin
                    w_rdnCntNext = r_rdnCnt + 5'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_rdnNext   = 1'b1;
            end
        endcase
    end

    // FIFO handshake decode. A push into a full FIFO is kept only if a pop in
    // the same cycle frees a slot. A pop from an empty FIFO does nothing.
    always_comb begin
        w_empty      = (r_count == '0);
        w_full       = (r_count == FULL_COUNT);
        w_pop        = bus.rd_en && !w_empty;
        w_pushAccept = w_push && (!w_full || w_pop);
        w_drop       = w_push && w_full && !w_pop;
        w_entry      = {bus.rx_frame_error, bus.rx_parity_error, bus.rx_data};
        w_head       = r_mem[r_rdPtr];
    end

    // FIFO storage. It needs no reset because the outputs are masked while empty.
    always_ff @(posedge clk16x) begin
        if (!clr && w_pushAccept) begin
            r_mem[r_wrPtr] <= w_entry;
        end
    end

    // FIFO pointers wrap modulo DEPTH. The occupancy count is one bit wider so
    // that it can hold DEPTH.
    always_ff @(posedge clk16x) begin
        if (clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushAccept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_pushAccept, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun flag. A drop in the same cycle as a clear leaves it set.
    always_ff @(posedge clk16x) begin
        if (clr) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    // Error counter next values. A clear is applied first so that an increment
    // in the same cycle still counts, and the count stops at 255.
    always_comb begin
        w_perrNext = bus.clr_cnt ? 8'd0 : r_perrCnt;
        w_ferrNext = bus.clr_cnt ? 8'd0 : r_ferrCnt;
        if (w_push && bus.rx_parity_error && (w_perrNext != 8'hFF)) begin
            w_perrNext = w_perrNext + 8'd1;
        end
        if (w_push && bus.rx_frame_error && (w_ferrNext != 8'hFF)) begin
            w_ferrNext = w_ferrNext + 8'd1;
        end
    end

    // Error counters, which also count bytes that were dropped on overrun.
    always_ff @(posedge clk16x) begin
        if (clr) begin
            r_perrCnt <= 8'd0;
            r_ferrCnt <= 8'd0;
        end else begin
            r_perrCnt <= w_perrNext;
            r_ferrCnt <= w_ferrNext;
        end
    end

    // Registered interrupt: data is waiting or a byte was lost.
    always_ff @(posedge clk16x) begin
        if (clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= bus.irq_en && (!w_empty || r_overrun);
        end
    end

    assign bus.cnt16x   = r_cnt16;
    assign bus.rx_rdn   = r_rdn;
    assign bus.rd_data  = w_empty ? 8'd0 : w_head[7:0];
    assign bus.rd_perr  = w_empty ? 1'b0 : w_head[8];
    assign bus.rd_ferr  = w_empty ? 1'b0 : w_head[9];
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.count    = r_count;
    assign bus.overrun  = r_overrun;
    assign bus.perr_cnt = r_perrCnt;
    assign bus.ferr_cnt = r_ferrCnt;
    assign bus.irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. A queue-based reference model runs
// beside the DUT on every edge. Directed table-driven sequences and a random
// phase drive both of them.
module tb_uart_rx_ctrl;

    localparam int DEPTH      = 8;
    localparam int AW         = 3;
    localparam int RDN_CYCLES = 16;

    logic clk16x;
    logic clr;

    uart_rx_ctrl_if #(.AW(AW)) intf ();

    uart_rx_ctrl #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .RDN_CYCLES (RDN_CYCLES)
    ) dut (
        .clk16x (clk16x),
        .clr    (clr),
        .bus    (intf.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state, expressed as a queue and simple counts.
    int         mCnt16;
    bit         mRdn;
    int         mLowLeft;
    bit         mPending;
    logic [9:0] mQ[$];
    bit         mOvr;
    int         mPerr;
    int         mFerr;
    bit         mIrq;
    bit         checkEnable = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         expCount;
        bit         expOvr;
        bit         expFull;
    } frameVec_t;

    frameVec_t vec[9];

    // x16 baud clock.
    initial begin
        clk16x = 1'b0;
        forever #5 clk16x = ~clk16x;
    end

    task automatic checkValue(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advances the model by one edge, using the inputs the DUT sampled at that edge.
    task automatic modelStep();
        bit         pushNow;
        bit         popNow;
        bit         drop;
        bit         irqNew;
        logic [9:0] entry;
        if (clr) begin
            mCnt16      = 0;
            mRdn        = 1'b1;
            mLowLeft    = 0;
            mPending    = 1'b0;
            mQ.delete();
            mOvr        = 1'b0;
            mPerr       = 0;
            mFerr       = 0;
            mIrq        = 1'b0;
            checkEnable = 1'b1;
            return;
        end
        irqNew  = intf.irq_en && ((mQ.size() != 0) || mOvr);
        pushNow = mPending;
        popNow  = intf.rd_en && (mQ.size() != 0);
        entry   = {intf.rx_frame_error, intf.rx_parity_error, intf.rx_data};
        drop    = 1'b0;
        if (popNow) void'(mQ.pop_front());
        if (pushNow) begin
            if (mQ.size() < DEPTH) mQ.push_back(entry);
            else drop = 1'b1;
        end
        if (drop) mOvr = 1'b1;
        else if (intf.clr_ovr) mOvr = 1'b0;
        if (intf.clr_cnt) begin
            mPerr = 0;
            mFerr = 0;
        end
        if (pushNow && intf.rx_parity_error && mPerr < 255) mPerr++;
        if (pushNow && intf.rx_frame_error && mFerr < 255) mFerr++;
        mPending = 1'b0;
        if (!mRdn) begin
            if (mLowLeft == 0) mRdn = 1'b1;
            else mLowLeft--;
        end else if (intf.rx_ready) begin
            mRdn     = 1'b0;
            mLowLeft = RDN_CYCLES - 1;
            mPending = 1'b1;
        end
        mCnt16 = (mCnt16 + 1) % 16;
        mIrq   = irqNew;
    endtask

    task automatic checkOutput();
        if (checkEnable) begin
            checkValue("model cnt16x", intf.cnt16x, mCnt16);
            checkValue("model rx_rdn", intf.rx_rdn, mRdn);
            checkValue("model count", intf.count, mQ.size());
            checkValue("model empty", intf.empty, mQ.size() == 0);
            checkValue("model full", intf.full, mQ.size() == DEPTH);
            checkValue("model rd_data", intf.rd_data, (mQ.size() != 0) ? mQ[0][7:0] : 0);
            checkValue("model rd_perr", intf.rd_perr, (mQ.size() != 0) ? mQ[0][8] : 0);
            checkValue("model rd_ferr", intf.rd_ferr, (mQ.size() != 0) ? mQ[0][9] : 0);
            checkValue("model overrun", intf.overrun, mOvr);
            checkValue("model perr_cnt", intf.perr_cnt, mPerr);
            checkValue("model ferr_cnt", intf.ferr_cnt, mFerr);
            checkValue("model irq", intf.irq, mIrq);
        end
    endtask

    // One clock edge: step the model, then sample the DUT 1 ns after the edge.
    task automatic applyStimulus();
        @(posedge clk16x);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        clr = 1'b1;
        applyStimulus();
        applyStimulus();
        clr = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] data, input bit perr, input bit ferr);
        intf.rx_data         = data;
        intf.rx_parity_error = perr;
        intf.rx_frame_error  = ferr;
        intf.rx_ready        = 1'b1;
        applyStimulus();
        intf.rx_ready = 1'b0;
        for (int i = 0; i < RDN_CYCLES + 1; i++) applyStimulus();
    endtask

    task automatic popEntry();
        intf.rd_en = 1'b1;
        applyStimulus();
        intf.rd_en = 1'b0;
    endtask

    initial begin
        int         lowCycles;
        logic [7:0] expOrder[8];

        clr                  = 1'b0;
        intf.rx_ready        = 1'b0;
        intf.rx_data         = 8'd0;
        intf.rx_parity_error = 1'b0;
        intf.rx_frame_error  = 1'b0;
        intf.rd_en           = 1'b0;
        intf.clr_ovr         = 1'b0;
        intf.clr_cnt         = 1'b0;
        intf.irq_en          = 1'b0;

        for (int i = 0; i < 9; i++) begin
            vec[i].data     = 8'(i + 1);
            vec[i].expCount = (i < 8) ? i + 1 : 8;
            vec[i].expOvr   = (i == 8);
            vec[i].expFull  = (i >= 7);
        end

        // Reset state.
        @(negedge clk16x);
        doReset();
        checkValue("reset count", intf.count, 0);
        checkValue("reset empty", intf.empty, 1);
        checkValue("reset rx_rdn", intf.rx_rdn, 1);
        checkValue("reset cnt16x", intf.cnt16x, 0);
        checkValue("reset irq", intf.irq, 0);

        // Single frame: strobe timing, 2-edge latency, interrupt.
        intf.irq_en          = 1'b1;
        intf.rx_data         = 8'hA5;
        intf.rx_ready        = 1'b1;
        applyStimulus();
        checkValue("strobe starts", intf.rx_rdn, 0);
        intf.rx_ready = 1'b0;
        applyStimulus();
        checkValue("latency count", intf.count, 1);
        checkValue("latency rd_data", intf.rd_data, 8'hA5);
        checkValue("latency rd_perr", intf.rd_perr, 0);
        checkValue("latency rd_ferr", intf.rd_ferr, 0);
        lowCycles = 2;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (intf.rx_rdn == 1'b1) break;
            lowCycles++;
        end
        checkValue("strobe length", lowCycles, RDN_CYCLES);
        checkValue("irq with data", intf.irq, 1);
        popEntry();

        // Table-driven fill past full, then drain in order.
        for (int i = 0; i < 9; i++) begin
            sendFrame(vec[i].data, 1'b0, 1'b0);
            checkValue("fill count", intf.count, vec[i].expCount);
            checkValue("fill overrun", intf.overrun, vec[i].expOvr);
            checkValue("fill full", intf.full, vec[i].expFull);
        end
        for (int i = 0; i < 8; i++) begin
            checkValue("drain order", intf.rd_data, vec[i].data);
            popEntry();
        end
        checkValue("drained empty", intf.empty, 1);
        popEntry();
        checkValue("underflow count", intf.count, 0);
        intf.clr_ovr = 1'b1;
        applyStimulus();
        intf.clr_ovr = 1'b0;
        checkValue("overrun cleared", intf.overrun, 0);

        // Full FIFO with a pop on the same edge as the push of 0x55.
        for (int i = 0; i < 8; i++) sendFrame(8'(8'h10 + i), 1'b0, 1'b0);
        intf.rx_data  = 8'h55;
        intf.rx_ready = 1'b1;
        applyStimulus();
        intf.rx_ready = 1'b0;
        intf.rd_en    = 1'b1;
        applyStimulus();
        intf.rd_en = 1'b0;
        checkValue("full push+pop count", intf.count, 8);
        checkValue("full push+pop overrun", intf.overrun, 0);
        for (int i = 0; i < RDN_CYCLES; i++) applyStimulus();
        for (int i = 0; i < 7; i++) expOrder[i] = 8'(8'h11 + i);
        expOrder[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            checkValue("push+pop order", intf.rd_data, expOrder[i]);
            popEntry();
        end

        // Error flags and counters.
        intf.clr_cnt = 1'b1;
        applyStimulus();
        intf.clr_cnt = 1'b0;
        sendFrame(8'h3C, 1'b1, 1'b0);
        checkValue("perr_cnt one", intf.perr_cnt, 1);
        checkValue("head perr", intf.rd_perr, 1);
        checkValue("head ferr clear", intf.rd_ferr, 0);
        popEntry();
        sendFrame(8'hC3, 1'b0, 1'b1);
        checkValue("ferr_cnt one", intf.ferr_cnt, 1);
        checkValue("perr_cnt held", intf.perr_cnt, 1);
        checkValue("head ferr", intf.rd_ferr, 1);
        checkValue("head perr clear", intf.rd_perr, 0);
        popEntry();
        intf.rd_en = 1'b1;
        for (int i = 0; i < 300; i++) sendFrame(8'(i), 1'b1, 1'b0);
        intf.rd_en = 1'b0;
        checkValue("perr_cnt saturates", intf.perr_cnt, 255);
        applyStimulus();

        // rx_ready held high after the read is accepted once.
        intf.rx_parity_error = 1'b0;
        intf.rx_data         = 8'h77;
        intf.rx_ready        = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus();
        intf.rx_ready = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus();
        checkValue("held ready single push", intf.count, 1);
        popEntry();

        // Reset during cycle 5 of READ.
        intf.rx_ready = 1'b1;
        applyStimulus();
        intf.rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        clr = 1'b1;
        applyStimulus();
        clr = 1'b0;
        checkValue("mid-read reset rx_rdn", intf.rx_rdn, 1);
        checkValue("mid-read reset count", intf.count, 0);
        checkValue("mid-read reset cnt16x", intf.cnt16x, 0);

        // Random traffic checked against the model.
        for (int i = 0; i < 4000; i++) begin
            intf.rx_ready        = ($urandom_range(0, 5) == 0);
            intf.rx_data         = 8'($urandom);
            intf.rx_parity_error = ($urandom_range(0, 3) == 0);
            intf.rx_frame_error  = ($urandom_range(0, 3) == 0);
            intf.rd_en           = ($urandom_range(0, 40) < ((i / 500) % 2 == 0 ? 2 : 20));
            intf.clr_ovr         = ($urandom_range(0, 19) == 0);
            intf.clr_cnt         = ($urandom_range(0, 29) == 0);
            intf.irq_en          = ($urandom_range(0, 3) != 0);
            clr                  = ($urandom_range(0, 399) == 0);
            applyStimulus();
        end
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART receiver. Runs on the receiver's x16 baud clock and generates the free-running cnt16x count the receiver needs.
- Detects r_ready, issues the active-low read strobe, captures the data byte and error flags, and pushes them into a small FIFO drained by the CPU.
- Keeps sticky overrun status, saturating parity/frame error counters and an interrupt.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, 3, log2(DEPTH).
- RDN_CYCLES, 16, clk16x cycles rx_rdn is held low per read; must be 2..16.

Ports:
- clk16x  in  1  baud*16 clock, the only clock.
- clr  in  1  synchronous reset, active-high.
- cnt16x  out  4  free-running x16 counter, to the receiver.
- rx_ready  in  1  receiver r_ready.
- rx_data  in  8  receiver d_out, valid while rx_rdn=0.
- rx_parity_error  in  1  receiver parity_error.
- rx_frame_error  in  1  receiver frame_error.
- rx_rdn  out  1  read strobe to the receiver, active low.
- rd_en  in  1  CPU pop request.
- rd_data  out  8  FIFO head byte (first-word-fall-through).
- rd_perr  out  1  parity flag of the head entry.
- rd_ferr  out  1  frame flag of the head entry.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  AW+1  FIFO occupancy, 0..DEPTH.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- clr_ovr  in  1  clear overrun.
- perr_cnt  out  8  saturating parity-error count.
- ferr_cnt  out  8  saturating frame-error count.
- clr_cnt  in  1  clear both counters.
- irq_en  in  1  interrupt enable.
- irq  out  1  interrupt.

Behaviour:
- Reset (clr=1 at a clk16x edge) takes priority over every other input:
  - cnt16x=0, rx_rdn=1, state IDLE.
  - FIFO empty: count=0, empty=1, full=0.
  - overrun=0, perr_cnt=0, ferr_cnt=0, irq=0.
  - rd_data/rd_perr/rd_ferr=0 while empty.
- cnt16x increments by 1 every cycle and wraps 15->0.
- FSM, two states, rx_rdn registered:
  - IDLE: rx_rdn=1. If rx_ready=1 at edge t, go to READ; rx_rdn=0 from edge t.
  - READ:
    - At the first edge in READ (t+1), capture {rx_frame_error, rx_parity_error, rx_data} and issue a push.
    - Hold rx_rdn=0 for RDN_CYCLES cycles in total, then return to IDLE with rx_rdn=1.
    - Holding the strobe suppresses duplicate r_ready assertions from the same frame.
    - rx_ready is ignored while in READ.
  - Read latency: rx_ready high to entry visible (count updated, empty=0) is 2 edges.
- FIFO:
  - Circular buffer with AW-bit pointers that wrap modulo DEPTH; count has AW+1 bits.
  - Push when full and no pop in the same cycle: byte dropped, overrun<=1.
  - Push and pop in the same cycle: both performed, count unchanged; valid when full (push accepted), not when empty.
  - Pop when empty is ignored; no underflow, count stays 0.
- overrun is cleared by clr_ovr. If a drop coincides with clr_ovr, overrun=1 (set wins).
- Error counters:
  - On each push, perr_cnt+=rd perr bit and ferr_cnt+=frame bit, each saturating at 255.
  - Dropped bytes still update the counters.
  - clr_cnt zeroes both; if an increment coincides with clr_cnt, the result is 0 then +1, i.e. 1.
- irq = irq_en & (!empty | overrun), registered, updated every edge.
- Reset mid-READ: rx_rdn returns high on the next edge; the captured byte is discarded if its push has not yet occurred.

Test Plan:
- Reset, then a single rx_ready pulse with rx_data=0xA5 and no errors -> rx_rdn low for exactly 16 cycles starting 1 edge later; after 2 edges count=1, rd_data=0xA5, rd_perr=0, rd_ferr=0; irq=1 when irq_en=1.
- Eight frames 0x01..0x08 with no pops, then a ninth frame 0x09 -> full=1, count=8, overrun=1, 0x09 dropped; eight pops return 0x01..0x08 in order, then empty=1 and a further pop leaves count=0.
- FIFO full and a pop coinciding with a push of 0x55 -> count stays 8, overrun stays 0, and 0x55 is the last entry read out.
- Frame with rx_parity_error=1, then one with rx_frame_error=1 -> perr_cnt=1, ferr_cnt=1; head flags match each entry; 300 parity-error frames -> perr_cnt=255.
- rx_ready held high for 16 cycles after the first read -> exactly one push.
- clr asserted during cycle 5 of READ -> next edge rx_rdn=1, count=0, cnt16x=0.
